// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default widths for the IF/MEM memory port arbiter
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_I    = 2'b01,
    GNT_D    = 2'b10
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signal bundle of the memory port arbiter
//  slave  : arbiter view (takes i_*/d_* requests and ram_ack/ram_rdata, drives ram_* and completions)
//  master : environment view (fetch stage, data stage and memory)
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_stall;

  logic              err;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_ack,
    output i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall, err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_ack,
    input  i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall, err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arb_wdog.sv
// rtl/mem_arb_wdog.sv - transaction watchdog: counts busy cycles, flags the TIMEOUT-th one
//  clk, rst_n : clock, asynchronous active-low reset
//  i_clr      : reload the count to zero (new transaction granted)
//  i_en       : a busy cycle is in progress
//  o_expire   : this busy cycle is the TIMEOUT-th since the last clear
module mem_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // The count holds the number of busy cycles already completed, so the
  // TIMEOUT-th busy cycle is the one that sees TIMEOUT-1. It parks there
  // until the next grant reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between fetch (read) and data (read/write)
//  clk, rst_n : clock, asynchronous active-low reset
//  bus.i_*    : fetch request/completion (i_req, i_addr -> i_rdata, i_ready, i_stall)
//  bus.d_*    : data request/completion (d_req, d_we, d_addr, d_wdata -> d_rdata, d_ready, d_stall)
//  bus.err    : pulses with ready when the transaction timed out
//  bus.ram_*  : registered memory request (ram_req, ram_we, ram_addr, ram_wdata) and response (ram_ack, ram_rdata)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_CAP = SW'(STARVE_MAX);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  grant_e            w_grant;
  logic              w_ack;
  logic              w_abort;
  logic              w_expire;
  logic              w_i_starved;
  logic              w_wdog_clr;
  logic              w_wdog_en;

  logic [SW-1:0]     r_starve;
  logic              r_ram_req;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_err;

  // Fetch has waited through STARVE_MAX data grants: data must yield once.
  assign w_i_starved = bus.i_req && (r_starve == STARVE_CAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = GNT_NONE;
    w_ack       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.d_req && !w_i_starved) begin
          w_grant     = GNT_D;
          w_state_nxt = ST_BUSY_D;
        end else if (bus.i_req) begin
          w_grant     = GNT_I;
          w_state_nxt = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // An ack landing on the expiry cycle still completes normally.
        if (bus.ram_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_wdog_clr = (w_grant != GNT_NONE);
  assign w_wdog_en  = (r_state != ST_IDLE);

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_wdog_clr),
    .i_en     (w_wdog_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve    <= '0;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;

      case (w_grant)
        GNT_D: begin
          r_ram_req   <= 1'b1;
          r_ram_we    <= bus.d_we;
          r_ram_addr  <= bus.d_addr;
          r_ram_wdata <= bus.d_wdata;
          if (!bus.i_req) begin
            r_starve <= '0;
          end else if (r_starve != STARVE_CAP) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        GNT_I: begin
          r_ram_req  <= 1'b1;
          r_ram_we   <= 1'b0;
          r_ram_addr <= bus.i_addr;
          r_starve   <= '0;
        end
        default: begin
        end
      endcase

      if (w_ack || w_abort) begin
        r_ram_req <= 1'b0;
        r_err     <= w_abort;
        if (r_state == ST_BUSY_I) begin
          r_i_ready <= 1'b1;
          r_i_rdata <= w_abort ? '0 : bus.ram_rdata;
        end else begin
          r_d_ready <= 1'b1;
          // Stores leave the last load data in place; an abort always zeroes it.
          if (w_abort) begin
            r_d_rdata <= '0;
          end else if (!r_ram_we) begin
            r_d_rdata <= bus.ram_rdata;
          end
        end
      end
    end
  end

  assign bus.ram_req   = r_ram_req;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.i_ready   = r_i_ready;
  assign bus.d_ready   = r_d_ready;
  assign bus.err       = r_err;
  assign bus.i_stall   = bus.i_req & ~r_i_ready;
  assign bus.d_stall   = bus.d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 8;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          dly;
  } req_t;

  typedef struct {
    int          cyc;
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          starve_m = 0;
  int          mem_bc = 0;
  int          mem_d = 0;
  int          gen_mode = 0;
  bit          i_pend, d_pend, mem_act, mem_is_d, done_i, done_d, ack_now;
  bit          prev_ram_req, exp_grant;
  logic [31:0] mem_rd;
  logic [31:0] exp_i_rd = '0;
  logic [31:0] exp_d_rd = '0;
  req_t        cur_i, cur_d;
  req_t        dq_i[$];
  req_t        dq_d[$];
  exp_t        sb[$];
  exp_t        mon_e;
  bit          mon_ei, mon_ed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic req_t rand_req(input bit allow_we);
    req_t r;
    r.we    = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
    r.addr  = $urandom() & 32'hFFFF_FFFC;
    r.wdata = $urandom();
    r.rd    = $urandom();
    r.dly   = 0;
    return r;
  endfunction

  // Mostly short latencies, plus ack on the last allowed cycle and no ack at all.
  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 10) return 1 + (r % 3);
    if (r < 12) return r - 6;
    if (r == 12) return TMO - 1;
    if (r == 13) return TMO;
    return TMO + 3;
  endfunction

  task automatic drive();
    bus.i_req   = i_pend;
    bus.i_addr  = cur_i.addr;
    bus.d_req   = d_pend;
    bus.d_we    = cur_d.we;
    bus.d_addr  = cur_d.addr;
    bus.d_wdata = cur_d.wdata;
  endtask

  function automatic bit all_idle();
    return !i_pend && !d_pend && !mem_act && !done_i && !done_d &&
           (sb.size() == 0) && (dq_i.size() == 0) && (dq_d.size() == 0);
  endfunction

  // One cycle of requesters + memory + model, run just after each rising edge.
  task automatic step();
    bit          rising, win_d, tmo;
    int          dd;
    logic [31:0] erd;
    req_t        w;
    cyc++;

    rising = bus.ram_req && !prev_ram_req;
    check("grant_timing", 32'(rising), 32'(exp_grant));
    if (rising && exp_grant) begin
      win_d = d_pend && !(i_pend && starve_m == SMAX);
      w = win_d ? cur_d : cur_i;
      check("grant_addr", bus.ram_addr, w.addr);
      check("grant_we", 32'(bus.ram_we), win_d ? 32'(w.we) : 32'd0);
      if (win_d) check("grant_wdata", bus.ram_wdata, w.wdata);
      if (win_d && i_pend) starve_m = (starve_m < SMAX) ? starve_m + 1 : SMAX;
      else starve_m = 0;
      dd  = (w.dly != 0) ? w.dly : pick_delay();
      tmo = (dd > TMO);
      if (tmo) erd = '0;
      else if (win_d && w.we) erd = exp_d_rd;
      else erd = w.rd;
      if (win_d) exp_d_rd = erd;
      else exp_i_rd = erd;
      sb.push_back('{cyc: cyc + (tmo ? TMO : dd), is_d: win_d, rdata: erd, err: tmo});
      mem_act = 1'b1; mem_bc = 0; mem_d = dd; mem_rd = w.rd; mem_is_d = win_d;
    end
    prev_ram_req = bus.ram_req;

    if (done_i) i_pend = 1'b0;
    if (done_d) d_pend = 1'b0;
    done_i = 1'b0;
    done_d = 1'b0;

    ack_now       = 1'b0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = $urandom();
    if (mem_act) begin
      mem_bc++;
      if (mem_bc > 1) check("ram_req_held", 32'(bus.ram_req), 32'd1);
      if (mem_bc == mem_d || mem_bc == TMO) begin
        if (mem_bc == mem_d) begin
          bus.ram_ack   = 1'b1;
          bus.ram_rdata = mem_rd;
        end
        mem_act = 1'b0;
        ack_now = 1'b1;
        if (mem_is_d) done_d = 1'b1;
        else done_i = 1'b1;
      end
    end else if (!bus.ram_req && $urandom_range(0, 7) == 0) begin
      bus.ram_ack = 1'b1;
    end

    if (!i_pend) begin
      if (dq_i.size() > 0) begin cur_i = dq_i.pop_front(); i_pend = 1'b1; end
      else if (gen_mode == 2 || (gen_mode == 1 && $urandom_range(0, 2) == 0)) begin
        cur_i = rand_req(1'b0); i_pend = 1'b1;
      end
    end
    if (!d_pend) begin
      if (dq_d.size() > 0) begin cur_d = dq_d.pop_front(); d_pend = 1'b1; end
      else if (gen_mode == 2 || (gen_mode == 1 && $urandom_range(0, 2) == 0)) begin
        cur_d = rand_req(1'b1); d_pend = 1'b1;
      end
    end

    exp_grant = !mem_act && !ack_now && (i_pend || d_pend);
    drive();
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1; step();
    end
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; step(); n++;
    end while (!all_idle() && n < max);
    if (!all_idle()) begin
      checks++;
      $display("FAIL drain actual=busy required=idle (cycle %0d)", cyc);
    end
  endtask

  always @(negedge clk) begin
    mon_ei = 1'b0;
    mon_ed = 1'b0;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      $display("FAIL ready_missing actual=none required=ready_at_%0d", sb[0].cyc);
      mon_e = sb.pop_front();
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_ei = !sb[0].is_d;
      mon_ed = sb[0].is_d;
    end
    check("i_ready", 32'(bus.i_ready), 32'(mon_ei));
    check("d_ready", 32'(bus.d_ready), 32'(mon_ed));
    check("i_stall", 32'(bus.i_stall), 32'(i_pend & !mon_ei));
    check("d_stall", 32'(bus.d_stall), 32'(d_pend & !mon_ed));
    if (mon_ei || mon_ed) begin
      mon_e = sb.pop_front();
      if (mon_e.is_d) check("d_rdata", bus.d_rdata, mon_e.rdata);
      else check("i_rdata", bus.i_rdata, mon_e.rdata);
      check("err", 32'(bus.err), 32'(mon_e.err));
    end else begin
      check("err_idle", 32'(bus.err), 32'd0);
    end
  end

  initial begin
    cur_i = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, rd: 32'h0, dly: 0};
    cur_d = cur_i;
    drive();
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_req", 32'(bus.ram_req), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", bus.ram_addr, 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_i_ready", 32'(bus.i_ready), 32'd0);
    check("rst_d_ready", 32'(bus.d_ready), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dq_d.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0,        rd: 32'hDEADBEEF, dly: 3});
    dq_d.push_back('{we: 1'b1, addr: 32'h040, wdata: 32'h12345678, rd: 32'h0BADF00D, dly: 1});
    dq_d.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0,        rd: 32'hCAFEF00D, dly: 1});
    dq_d.push_back('{we: 1'b0, addr: 32'h108, wdata: 32'h0,        rd: 32'hA5A5A5A5, dly: TMO});
    dq_i.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0,        rd: 32'h13579BDF, dly: 1});
    dq_i.push_back('{we: 1'b0, addr: 32'h20C, wdata: 32'h0,        rd: 32'h55AA55AA, dly: TMO + 1});
    dq_d.push_back('{we: 1'b1, addr: 32'h044, wdata: 32'h87654321, rd: 32'h0,        dly: TMO + 1});
    run_until_idle(300);

    gen_mode = 1;
    run_n(1500);
    gen_mode = 2;
    run_n(400);
    gen_mode = 0;
    run_until_idle(300);

    dq_d.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, rd: 32'h0, dly: 100});
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #1; step(); n++;
      end while (!(mem_act && mem_bc >= 3) && n < 50);
      if (!(mem_act && mem_bc >= 3)) begin
        checks++;
        $display("FAIL busy_d_wait actual=idle required=busy (cycle %0d)", cyc);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ram_req", 32'(bus.ram_req), 32'd0);
    check("arst_ram_we", 32'(bus.ram_we), 32'd0);
    check("arst_ram_addr", bus.ram_addr, 32'd0);
    check("arst_d_ready", 32'(bus.d_ready), 32'd0);
    check("arst_d_rdata", bus.d_rdata, 32'd0);
    check("arst_err", 32'(bus.err), 32'd0);
    sb.delete();
    mem_act = 1'b0; done_i = 1'b0; done_d = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    starve_m = 0; exp_i_rd = '0; exp_d_rd = '0;
    prev_ram_req = 1'b0; exp_grant = 1'b0;
    bus.ram_ack = 1'b0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dq_d.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, rd: 32'hDEADBEEF, dly: 3});
    run_until_idle(50);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
